// File: rtl/temple_pkg.sv
// Shared types for the run sequencer: game states, lanes, offsets.
// Also maps a lane to the head layer's horizontal offset.
package temple_pkg;

  typedef enum logic [1:0] {
    COUNTDOWN,
    LOGO_SCROLL,
    HEAD_SLIDE,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    LEFT,
    CENTER,
    RIGHT
  } lane_t;

  typedef logic signed [11:0] offset_t;

  // Left lane sits at +mag, right lane at -mag.
  function automatic offset_t lane_hoffset(
    input lane_t   lane,
    input offset_t mag
  );
    offset_t r;
    r = '0;
    unique case (lane)
      LEFT:    r = mag;
      RIGHT:   r = -mag;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer plus rising-edge pulse for a raw button.
// Ports: clk, rst (sync, active-high), btn_raw (async in), press (1-clk pulse).
module button_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  // [0],[1] synchronize; [2] holds the previous synced level.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_raw};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign press = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/run_sequencer.sv
// Frame-rate sequencer: countdown, logo scroll, head slide, then gameplay.
// Ports: clk, rst, vsync, btn_left/right in; layer offsets, state, running out.
module run_sequencer
  import temple_pkg::*;
#(
  parameter int COUNTDOWN_FRAMES = 45,
  parameter int LOGO_STEP        = 30,
  parameter int LOGO_END         = -600,
  parameter int HEAD_START       = -170,
  parameter int HEAD_STEP        = 17,
  parameter int LANE_OFFSET      = 100,
  parameter int COIN_WRAP        = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [11:0] logo_voffset,
  output logic [11:0] head_hoffset,
  output logic [11:0] head_voffset,
  output logic [11:0] coin_step,
  output logic [1:0]  state,
  output logic        running
);

  localparam logic signed [12:0] L_STEP = 13'(LOGO_STEP);
  localparam logic signed [12:0] L_END  = 13'(LOGO_END);
  localparam logic signed [12:0] H_STEP = 13'(HEAD_STEP);
  localparam offset_t            H_INIT = 12'(HEAD_START);
  localparam offset_t            L_MAG  = 12'(LANE_OFFSET);
  localparam logic [11:0]        C_LAST = 12'(COIN_WRAP - 1);
  localparam logic [11:0]        CD_INIT = 12'(COUNTDOWN_FRAMES);

  logic press_l;
  logic press_r;

  button_sync_edge u_left (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_left),
    .press   (press_l)
  );

  button_sync_edge u_right (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_right),
    .press   (press_r)
  );

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  offset_t     logo_q, logo_d;
  offset_t     headv_q, headv_d;
  offset_t     headh_q, headh_d;
  lane_t       lane_q, lane_d;
  logic [11:0] coin_q, coin_d;
  logic        run_q, run_d;
  logic        pl_q, pl_d;
  logic        pr_q, pr_d;
  logic        vsync_q;
  logic        tick;

  logic signed [12:0] logo_nx;
  logic signed [12:0] head_nx;

  assign tick    = vsync & ~vsync_q;
  // Widened by one bit so the clamp test never sees a wrapped value.
  assign logo_nx = {logo_q[11], logo_q} - L_STEP;
  assign head_nx = {headv_q[11], headv_q} + H_STEP;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    logo_d  = logo_q;
    headv_d = headv_q;
    lane_d  = lane_q;
    coin_d  = coin_q;
    run_d   = run_q;
    // A press landing on the tick cycle survives into the next frame.
    pl_d    = tick ? press_l : (pl_q | press_l);
    pr_d    = tick ? press_r : (pr_q | press_r);
    if (tick) begin
      unique case (state_q)
        COUNTDOWN: begin
          cnt_d = cnt_q - 12'd1;
          if (cnt_q == 12'd1) state_d = LOGO_SCROLL;
        end
        LOGO_SCROLL: begin
          if (logo_nx <= L_END) begin
            logo_d  = L_END[11:0];
            state_d = HEAD_SLIDE;
          end else begin
            logo_d = logo_nx[11:0];
          end
        end
        HEAD_SLIDE: begin
          if (head_nx >= 13'sd0) begin
            headv_d = '0;
            state_d = RUN;
            run_d   = 1'b1;
          end else begin
            headv_d = head_nx[11:0];
          end
        end
        default: begin
          coin_d = (coin_q == C_LAST) ? 12'd0 : coin_q + 12'd1;
          if (pl_q && !pr_q) begin
            lane_d = (lane_q == RIGHT) ? CENTER : LEFT;
          end else if (pr_q && !pl_q) begin
            lane_d = (lane_q == LEFT) ? CENTER : RIGHT;
          end
        end
      endcase
    end
    headh_d = lane_hoffset(lane_d, L_MAG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COUNTDOWN;
      cnt_q   <= CD_INIT;
      logo_q  <= '0;
      headv_q <= H_INIT;
      headh_q <= '0;
      lane_q  <= CENTER;
      coin_q  <= '0;
      run_q   <= 1'b0;
      pl_q    <= 1'b0;
      pr_q    <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      logo_q  <= logo_d;
      headv_q <= headv_d;
      headh_q <= headh_d;
      lane_q  <= lane_d;
      coin_q  <= coin_d;
      run_q   <= run_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      vsync_q <= vsync;
    end
  end

  assign logo_voffset = logo_q;
  assign head_hoffset = headh_q;
  assign head_voffset = headv_q;
  assign coin_step    = coin_q;
  assign state        = state_q;
  assign running      = run_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench for run_sequencer with a frame-level reference model.
// Two instances: default steps and a clamp-exercising step set.
module tb_run_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic vsync;
  logic btn_left;
  logic btn_right;

  logic [11:0] lv [2];
  logic [11:0] hh [2];
  logic [11:0] hv [2];
  logic [11:0] cs [2];
  logic [1:0]  st [2];
  logic        rn [2];

  always #5 clk = ~clk;

  run_sequencer dut0 (
    .clk          (clk),
    .rst          (rst),
    .vsync        (vsync),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .logo_voffset (lv[0]),
    .head_hoffset (hh[0]),
    .head_voffset (hv[0]),
    .coin_step    (cs[0]),
    .state        (st[0]),
    .running      (rn[0])
  );

  run_sequencer #(
    .LOGO_STEP (35),
    .HEAD_STEP (30)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .vsync        (vsync),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .logo_voffset (lv[1]),
    .head_hoffset (hh[1]),
    .head_voffset (hv[1]),
    .coin_step    (cs[1]),
    .state        (st[1]),
    .running      (rn[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Phases: 0 countdown, 1 logo, 2 head, 3 run.
  int lstep [2] = '{30, 35};
  int hstep [2] = '{17, 30};
  int m_ph [2];
  int m_cnt [2];
  int m_logo [2];
  int m_head [2];
  int m_pos [2];
  int m_runticks [2];
  bit m_pl [2];
  bit m_pr [2];

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_cnt[k] = 45; m_logo[k] = 0;
      m_head[k] = -170; m_pos[k] = 0; m_runticks[k] = 0;
      m_pl[k] = 0; m_pr[k] = 0;
    end
  endfunction

  function automatic void m_tick();
    for (int k = 0; k < 2; k++) begin
      if (m_ph[k] == 0) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) m_ph[k] = 1;
      end else if (m_ph[k] == 1) begin
        m_logo[k] -= lstep[k];
        if (m_logo[k] <= -600) begin m_logo[k] = -600; m_ph[k] = 2; end
      end else if (m_ph[k] == 2) begin
        m_head[k] += hstep[k];
        if (m_head[k] >= 0) begin m_head[k] = 0; m_ph[k] = 3; end
      end else begin
        m_runticks[k]++;
        if (m_pl[k] && !m_pr[k] && m_pos[k] > -1) m_pos[k]--;
        if (m_pr[k] && !m_pl[k] && m_pos[k] < 1) m_pos[k]++;
      end
      m_pl[k] = 0; m_pr[k] = 0;
    end
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "/state"}, int'(st[k]), m_ph[k]);
      chk({tag, "/logo"}, int'($signed(lv[k])), m_logo[k]);
      chk({tag, "/headv"}, int'($signed(hv[k])), m_head[k]);
      chk({tag, "/headh"}, int'($signed(hh[k])), -100 * m_pos[k]);
      chk({tag, "/coin"}, int'(cs[k]), m_runticks[k] % 60);
      chk({tag, "/run"}, int'(rn[k]), (m_ph[k] == 3) ? 1 : 0);
    end
  endtask

  task automatic pulse(input int hold);
    @(negedge clk);
    vsync = 1'b1;
    m_tick();
    repeat (hold) @(negedge clk);
    vsync = 1'b0;
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic press(input bit l, input bit r);
    @(negedge clk);
    btn_left = l;
    btn_right = r;
    repeat (3) @(negedge clk);
    btn_left = 1'b0;
    btn_right = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_pl[k] |= l;
      m_pr[k] |= r;
    end
  endtask

  function automatic bit both_run();
    return m_ph[0] == 3 && m_ph[1] == 3;
  endfunction

  initial begin
    rst = 1'b1;
    vsync = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);

    press(1'b1, 1'b0);
    for (int i = 0; i < 45; i++) begin
      pulse($urandom_range(1, 4));
      check_all("countdown");
      if (i == 10) press(1'b1, 1'b0);
    end

    for (int i = 0; i < 60 && !both_run(); i++) begin
      if (m_ph[0] == 2 && !both_run()) press(1'b1, 1'b0);
      pulse($urandom_range(1, 4));
      check_all("intro");
    end
    chk("reached_run", int'(both_run()), 1);

    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0);
      pulse(2);
      check_all("left");
    end
    for (int i = 0; i < 2; i++) begin
      press(1'b0, 1'b1);
      pulse(2);
      check_all("right");
    end
    press(1'b1, 1'b1);
    pulse(2);
    check_all("both");
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    pulse(2);
    check_all("both_split");

    for (int i = 0; i < 70; i++) begin
      case ($urandom_range(0, 4))
        0: press(1'b1, 1'b0);
        1: press(1'b0, 1'b1);
        2: press(1'b1, 1'b1);
        default: ;
      endcase
      pulse($urandom_range(1, 5));
      check_all("rand");
    end

    pulse(50);
    check_all("long_vsync");

    press(1'b0, 1'b1);
    pulse(1);
    press(1'b0, 1'b1);
    pulse(1);
    check_all("pre_reset");

    @(negedge clk);
    rst = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    m_reset();
    check_all("reset_tick");
    rst = 1'b0;
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    check_all("post_reset");
    pulse(2);
    check_all("after_reset_tick");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
